store_checker: RTL and testbench

- Sits directly downstream of the processor top's data-store port (memwrite, dataadr, writedata); samples every store on the rising clock edge.
- Decides pass/fail/timeout against a parameterised target store and keeps an optional FIFO trace log of stores.
- Replaces ad-hoc bench checking with a synthesizable, sticky verdict usable in simulation and on FPGA.

---
 rtl/store_checker_pkg.sv | 22 ++
 rtl/store_log_fifo.sv | 63 ++++++
 rtl/store_checker.sv | 111 +++++++++++
 tb/tb_store_checker.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/store_checker_pkg.sv
// Shared types and sizing helpers for the store checker and its trace log.
package store_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3,
    ST_TOUT = 3'd4
  } state_t;

  // One log entry packs {address, data}.
  function automatic int entry_w(input int aw, input int dw);
    return aw + dw;
  endfunction

  // Occupancy counter must hold the value DEPTH itself.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/store_log_fifo.sv
// Synchronous first-word-fall-through FIFO holding {addr, data} store entries,
// with a sticky overflow flag for pushes dropped while full.
module store_log_fifo
  import store_checker_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [AW-1:0]             in_addr,
  input  logic [DW-1:0]             in_data,
  output logic                      empty,
  output logic                      full,
  output logic [count_w(DEPTH)-1:0] count,
  output logic                      ovf,
  output logic [AW-1:0]             out_addr,
  output logic [DW-1:0]             out_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);
  localparam int EW = entry_w(AW, DW);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  logic [EW-1:0] head;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot, so a push at full is still accepted.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (push && !do_push) ovf <= 1'b1;
    end
  end

  // NOTE: storage array has no reset; only pointers and count define validity,
  // which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {in_addr, in_data};
  end

  assign head                 = mem[rd_ptr];
  assign {out_addr, out_data} = empty ? '0 : head;

endmodule

// File: rtl/store_checker.sv
// Watches the processor data-store port and produces a sticky pass/fail/timeout
// verdict. Optional trace log of RUN stores enabled by STORE_CHECKER_TRACE_EN.
module store_checker
  import store_checker_pkg::*;
#(
  parameter int            DW             = 32,
  parameter int            AW             = 32,
  parameter logic [AW-1:0] PASS_ADDR      = 84,
  parameter logic [DW-1:0] PASS_DATA      = 7,
  parameter logic [AW-1:0] IGNORE_ADDR    = 80,
  parameter int            TIMEOUT_CYCLES = 1024,
  parameter int            LOG_DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          arm,
  input  logic                          memwrite,
  input  logic [AW-1:0]                 dataadr,
  input  logic [DW-1:0]                 writedata,
  output logic                          done,
  output logic                          pass,
  output logic                          fail,
  output logic                          timeout,
  output logic [15:0]                   store_count,
  input  logic                          log_pop,
  output logic                          log_empty,
  output logic [AW-1:0]                 log_addr,
  output logic [DW-1:0]                 log_data,
  output logic [count_w(LOG_DEPTH)-1:0] log_count,
  output logic                          log_ovf
);

  localparam int            TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t        state, state_nxt;
  logic [TW-1:0] cyc;
  logic          store_event;

  assign store_event = (state == ST_RUN) && memwrite;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it unassigned
  // (otherwise a latch is inferred).
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (arm) state_nxt = ST_RUN;
      ST_RUN: begin
        if (store_event) begin
          if (dataadr == PASS_ADDR && writedata == PASS_DATA) state_nxt = ST_PASS;
          else if (dataadr != IGNORE_ADDR)                    state_nxt = ST_FAIL;
        end
        // A store verdict on this edge outranks the timeout.
        if (state_nxt == ST_RUN && TIMEOUT_CYCLES != 0 && cyc == T_LAST)
          state_nxt = ST_TOUT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc         <= '0;
      store_count <= '0;
    end else begin
      cyc <= (state == ST_RUN) ? cyc + 1'b1 : '0;
      if (store_event && store_count != 16'hFFFF) store_count <= store_count + 1'b1;
    end
  end

  assign pass    = (state == ST_PASS);
  assign fail    = (state == ST_FAIL);
  assign timeout = (state == ST_TOUT);
  assign done    = pass || fail || timeout;

`ifdef STORE_CHECKER_TRACE_EN
  logic log_full;

  store_log_fifo #(.AW(AW), .DW(DW), .DEPTH(LOG_DEPTH)) u_log (
    .clk      (clk),
    .reset    (reset),
    .push     (store_event),
    .pop      (log_pop),
    .in_addr  (dataadr),
    .in_data  (writedata),
    .empty    (log_empty),
    .full     (log_full),
    .count    (log_count),
    .ovf      (log_ovf),
    .out_addr (log_addr),
    .out_data (log_data)
  );
`else
  logic unused_log_pop;

  assign unused_log_pop = log_pop;
  assign log_empty      = 1'b1;
  assign log_addr       = '0;
  assign log_data       = '0;
  assign log_count      = '0;
  assign log_ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_store_checker.sv
// Directed self-checking bench for store_checker (TIMEOUT_CYCLES=16, LOG_DEPTH=8);
// log expectations follow whether STORE_CHECKER_TRACE_EN is defined.
module tb_store_checker;
  import store_checker_pkg::*;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int LOG_DEPTH = 8;
  localparam int CW        = count_w(LOG_DEPTH);

  logic          clk = 1'b0;
  logic          reset, arm, memwrite, log_pop;
  logic [AW-1:0] dataadr, log_addr;
  logic [DW-1:0] writedata, log_data;
  logic          done, pass, fail, timeout, log_empty, log_ovf;
  logic [15:0]   store_count;
  logic [CW-1:0] log_count;

  int checks = 0;
  int errors = 0;
  bit trace;

  always #5 clk = ~clk;

  store_checker #(.DW(DW), .AW(AW), .TIMEOUT_CYCLES(16), .LOG_DEPTH(LOG_DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .memwrite    (memwrite),
    .dataadr     (dataadr),
    .writedata   (writedata),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .store_count (store_count),
    .log_pop     (log_pop),
    .log_empty   (log_empty),
    .log_addr    (log_addr),
    .log_data    (log_data),
    .log_count   (log_count),
    .log_ovf     (log_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_verdict(input string tag, input logic d, input logic p,
                               input logic f, input logic t);
    check({tag, ".done"},    done,    d);
    check({tag, ".pass"},    pass,    p);
    check({tag, ".fail"},    fail,    f);
    check({tag, ".timeout"}, timeout, t);
  endtask

  // Expected log state: real values with the trace log built, constants without it.
  task automatic check_log(input string tag, input int cnt, input logic ovf,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    check({tag, ".log_count"}, log_count, trace ? cnt : 0);
    check({tag, ".log_empty"}, log_empty, trace ? (cnt == 0) : 1'b1);
    check({tag, ".log_ovf"},   log_ovf,   trace ? ovf : 1'b0);
    check({tag, ".log_addr"},  log_addr,  (trace && cnt != 0) ? a : '0);
    check({tag, ".log_data"},  log_data,  (trace && cnt != 0) ? d : '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    step();
    memwrite  = 1'b0;
  endtask

  task automatic pop();
    log_pop = 1'b1;
    step();
    log_pop = 1'b0;
  endtask

  // Pulses reset between edges so the caller stays aligned to posedge+1.
  task automatic reset_dut();
    arm      = 1'b0;
    memwrite = 1'b0;
    log_pop  = 1'b0;
    reset    = 1'b0;
    #2;
    reset    = 1'b1;
  endtask

  initial begin
`ifdef STORE_CHECKER_TRACE_EN
    trace = 1'b1;
`else
    trace = 1'b0;
`endif
    reset = 1'b0; arm = 1'b1; memwrite = 1'b0; log_pop = 1'b0;
    dataadr = '0; writedata = '0;

    // Reset held for 22 ns with arm high.
    #20;
    check_verdict("reset", 0, 0, 0, 0);
    check("reset.store_count", store_count, 16'd0);
    check_log("reset", 0, 0, '0, '0);
    #2 reset = 1'b1;
    step();                              // edge with arm=1: IDLE -> RUN

    // Ignored store then passing store.
    store(80, 3);
    check_verdict("p1.after80", 0, 0, 0, 0);
    store(84, 7);
    check_verdict("p1.pass", 1, 1, 0, 0);
    check("p1.store_count", store_count, 16'd2);
    check_log("p1.head0", 2, 0, 80, 3);
    pop();
    check_log("p1.head1", 1, 0, 84, 7);
    pop();
    check_log("p1.drained", 0, 0, '0, '0);
    pop();                               // pop on empty is ignored
    check_log("p1.pop_empty", 0, 0, '0, '0);
    check_verdict("p1.sticky", 1, 1, 0, 0);

    // Wrong data at the pass address fails; later stores change nothing.
    reset_dut();
    arm = 1'b1;
    step();
    store(84, 5);
    check_verdict("f1.fail", 1, 0, 1, 0);
    check("f1.store_count", store_count, 16'd1);
    store(80, 3);
    store(84, 7);
    check_verdict("f1.sticky", 1, 0, 1, 0);
    check("f1.store_count_frozen", store_count, 16'd1);
    check_log("f1.log", 1, 0, 84, 5);

    // Timeout exactly 16 cycles after RUN entry.
    reset_dut();
    arm = 1'b1;
    step();                              // RUN entry edge
    for (int i = 0; i < 15; i++) step();
    check_verdict("t1.before", 0, 0, 0, 0);
    step();
    check_verdict("t1.timeout", 1, 0, 0, 1);
    check("t1.store_count", store_count, 16'd0);

    // A passing store on the timeout edge wins.
    reset_dut();
    arm = 1'b1;
    step();
    for (int i = 0; i < 15; i++) step();
    store(84, 7);
    check_verdict("t2.pass_beats_tout", 1, 1, 0, 0);

    // Overflow: eleven ignored-address stores into an 8-entry log.
    reset_dut();
    arm = 1'b1;
    step();
    for (int i = 0; i < 8; i++) store(80, i);
    check_log("o1.full", 8, 0, 80, 0);
    for (int i = 8; i < 11; i++) store(80, i);
    check("o1.store_count", store_count, 16'd11);
    check_verdict("o1.running", 0, 0, 0, 0);
    check_log("o1.ovf", 8, 1, 80, 0);
    log_pop = 1'b1;
    store(80, 99);                       // pop and push together at full
    log_pop = 1'b0;
    check_log("o1.push_pop_full", 8, 1, 80, 1);
    check("o1.store_count2", store_count, 16'd12);

    // Stores before arm are ignored.
    reset_dut();
    store(84, 7);
    store(90, 1);
    check("i1.store_count", store_count, 16'd0);
    check_verdict("i1.idle", 0, 0, 0, 0);
    check_log("i1.log", 0, 0, '0, '0);

    // Reset pulse mid-RUN.
    arm = 1'b1;
    step();
    store(80, 3);
    check("r1.store_count", store_count, 16'd1);
    arm   = 1'b0;
    reset = 1'b0;
    #1;
    check_verdict("r1.in_reset", 0, 0, 0, 0);
    check("r1.store_count_cleared", store_count, 16'd0);
    check_log("r1.log_cleared", 0, 0, '0, '0);
    reset = 1'b1;
    step();
    store(84, 5);                        // back in IDLE: no verdict
    check_verdict("r1.idle_after", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
